frame_capture_sequencer: RTL and testbench
==========================================

// Module: frame_capture_sequencer
// PURPOSE
//  Sequences camera frame capture into a two-bank (ping-pong) frame buffer.
//  Sits between the pixel-assembly/capture unit (which supplies w_en and X) and the M9K buffer.
//  Owns the row count, the write address and write gating, and bank ownership handoff to the frame reader.
//  Publishes completed frames to the reader with a one-cycle FRAME_DONE pulse.
// PARAMETERS
//  IMG_W    176  pixels per stored line; pixels with X >= IMG_W are not written
//  IMG_H    144  lines per stored frame; lines with row >= IMG_H are not written
//  BANK_AW  15   per-bank address width, >= clog2(IMG_W*IMG_H)
//  CNT_W    16   width of FRAME_CNT and DROP_CNT
// PORTS
//  CLK        in   1          pixel clock; VSYNC, HREF and PIX_WE are already in this domain
//  RST        in   1          reset, synchronous, active-high
//  VSYNC      in   1          camera frame sync; rising edge = frame boundary
//  HREF       in   1          camera line valid; falling edge = end of line
//  PIX_WE     in   1          pixel-ready strobe from the capture unit
//  PIX_X      in   15         pixel column from the capture unit
//  CAP_START  in   1          one-cycle request to begin capture
//  CAP_ABORT  in   1          one-cycle request to stop immediately
//  CAP_CONT   in   1          1 = continuous capture, 0 = single-shot; sampled on CAP_START
//  RD_BUSY    in   1          reader is scanning RD_BANK; banks must not swap while this is high
//  WR_EN      out  1          gated write enable to the frame buffer
//  WR_ADDR    out  BANK_AW+1  {WR_BANK, line_base + PIX_X}
//  RD_BANK    out  1          bank owned by the reader
//  FRAME_DONE out  1          one-cycle pulse when a frame is published to RD_BANK
//  BUSY       out  1          high in every state except IDLE
//  FRAME_CNT  out  CNT_W      number of published frames, wraps
//  DROP_CNT   out  CNT_W      number of frames discarded because RD_BUSY was high, saturates
// BEHAVIOUR
//  Reset values: state=IDLE, WR_BANK=0, RD_BANK=1, WR_EN=0, WR_ADDR=0, FRAME_DONE=0, counters=0.
//  Edge detection: VSYNC and HREF are registered once per CLK.
//   - rise = cur & ~prev; fall = ~cur & prev.
//   - prev is cleared by reset, so a signal already high at reset does not produce an edge.
//  States and transitions:
//   - IDLE: waits for CAP_START; latches the mode from CAP_CONT; goes to ARMED.
//   - ARMED: waits for VSYNC rise. row=0, line_base=0, then goes to CAPTURE.
//     A partial frame is never captured.
//   - CAPTURE: on HREF fall, row++ and line_base += IMG_W (adder, no multiplier).
//     On VSYNC rise, goes to SWAP.
//   - SWAP, RD_BUSY=0: WR_BANK and RD_BANK exchange. FRAME_DONE=1 for this cycle and FRAME_CNT++.
//     Next state is IDLE in single-shot mode, CAPTURE (row and line_base reset) in continuous mode.
//   - SWAP, RD_BUSY=1, continuous mode: the frame is dropped. DROP_CNT++, no swap, the next frame
//     overwrites the same WR_BANK, and the state goes to CAPTURE with row reset.
//   - SWAP, RD_BUSY=1, single-shot mode: stays in SWAP until RD_BUSY=0, then publishes.
//  Write gating: WR_EN = PIX_WE & (state==CAPTURE) & (row < IMG_H) & (PIX_X < IMG_W).
//   - WR_EN and WR_ADDR are registered: one-cycle latency from PIX_WE.
//   - The pixel data path must be delayed one cycle externally to line up.
//  Priority: RST > CAP_ABORT > normal transitions.
//   - CAP_ABORT goes to IDLE next cycle from any state, including SWAP.
//   - On abort: no swap, no FRAME_DONE, WR_EN=0, banks unchanged.
//  CAP_START outside IDLE is ignored.
//  A VSYNC rise in the same cycle as an HREF fall: frame end wins; the row increment is discarded.
//  line_base and row stop advancing once row reaches IMG_H (no wrap into the other bank).
//  Reset asserted mid-capture: all state returns to the reset values the next cycle.
// STRUCTURE
//  Shared package cam_pkg: IMG_W, IMG_H, BANK_AW, the state encoding
//  (IDLE, ARMED, CAPTURE, SWAP as localparams).
//  One sub-module, sync_edge_detect (1 register, rise/fall outputs).
//  It is instanced twice, for VSYNC and HREF.
//  The FSM, address generator and counters stay in this module.
// TESTING
//  1. RST, then CAP_START with CAP_CONT=0, then one 176x144 frame between two VSYNC rises, RD_BUSY=0
//     -> 25344 WR_EN pulses, addresses 0..25343 in bank 0, FRAME_DONE once, RD_BANK=0, FRAME_CNT=1,
//     IDLE after.
//  2. Continuous mode, 3 frames, RD_BUSY=0 -> RD_BANK toggles 1->0->1->0, FRAME_CNT=3.
//     The 2nd frame's addresses start at 0x8000.
//  3. Continuous mode with RD_BUSY=1 held over the 2nd frame end -> DROP_CNT=1, no swap.
//     The 3rd frame rewrites the same bank; FRAME_CNT=2 after 3 frames.
//  4. Single-shot mode, RD_BUSY=1 at frame end for 50 cycles -> remains in SWAP.
//     FRAME_DONE exactly 1 cycle after RD_BUSY falls.
//  5. Camera sends 180-pixel lines and 150 lines -> no WR_EN for X>=176 or row>=144,
//     max WR_ADDR offset 25343.
//  6. CAP_ABORT at line 70; separately, RST mid-line -> IDLE next cycle, WR_EN=0 next cycle,
//     no FRAME_DONE, banks unchanged (abort) or at reset values (RST).

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the camera frame capture path.
package cam_pkg;

  localparam int unsigned IMG_W   = 176;  // pixels per stored line
  localparam int unsigned IMG_H   = 144;  // lines per stored frame
  localparam int unsigned BANK_AW = 15;   // per-bank address width
  localparam int unsigned CNT_W   = 16;   // FRAME_CNT / DROP_CNT width

  // Row counter must be able to hold IMG_H itself (the saturation value)
  localparam int unsigned ROW_W = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StSwap    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Single-register edge detector for a signal already in the CLK domain.
module sync_edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_q;

  // Previous-cycle copy of din, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) prev_q <= 1'b0;
    else     prev_q <= din;
  end

  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

endmodule

// File: rtl/frame_capture_sequencer.sv
// Sequences camera frame capture into a ping-pong frame buffer and hands
// completed banks to the frame reader.
module frame_capture_sequencer
  import cam_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               VSYNC,
  input  logic               HREF,
  input  logic               PIX_WE,
  input  logic [BANK_AW-1:0] PIX_X,
  input  logic               CAP_START,
  input  logic               CAP_ABORT,
  input  logic               CAP_CONT,
  input  logic               RD_BUSY,
  output logic               WR_EN,
  output logic [BANK_AW:0]   WR_ADDR,
  output logic               RD_BANK,
  output logic               FRAME_DONE,
  output logic               BUSY,
  output logic [CNT_W-1:0]   FRAME_CNT,
  output logic [CNT_W-1:0]   DROP_CNT
);

  localparam logic [ROW_W-1:0]   ROW_LIM   = ROW_W'(IMG_H);
  localparam logic [BANK_AW-1:0] LINE_STEP = BANK_AW'(IMG_W);

  logic vsync_rise, vsync_fall, href_rise, href_fall;

  sync_edge_detect u_vsync_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (VSYNC),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  sync_edge_detect u_href_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (HREF),
    .rise (href_rise),
    .fall (href_fall)
  );

  logic unused_edges;
  assign unused_edges = vsync_fall ^ href_rise;

  state_e             state_q, state_d;
  logic               cont_q, cont_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BANK_AW-1:0] base_q, base_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [BANK_AW:0]   wr_addr_q, wr_addr_d;

  // Next-state logic for the capture FSM, line addressing, banks and counters
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    row_d       = row_q;
    base_d      = base_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (CAP_START) begin
          cont_d  = CAP_CONT;
          state_d = StArmed;
        end
      end
      StArmed: begin
        // Wait for a frame boundary so a partial frame is never stored
        if (vsync_rise) begin
          row_d   = '0;
          base_d  = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        // Frame end wins over a coincident line end
        if (vsync_rise) begin
          state_d = StSwap;
        end else if (href_fall && (row_q < ROW_LIM)) begin
          row_d  = row_q + ROW_W'(1);
          base_d = base_q + LINE_STEP;
        end
      end
      StSwap: begin
        if (!RD_BUSY) begin
          wr_bank_d   = rd_bank_q;
          rd_bank_d   = wr_bank_q;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          row_d       = '0;
          base_d      = '0;
          state_d     = cont_q ? StCapture : StIdle;
        end else if (cont_q) begin
          // Reader still busy: discard this frame and overwrite the same bank
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          row_d   = '0;
          base_d  = '0;
          state_d = StCapture;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: no publish, banks and counters untouched
    if (CAP_ABORT) begin
      state_d     = StIdle;
      row_d       = row_q;
      base_d      = base_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
    end
  end

  // Write gating and address; registered so WR_EN lags PIX_WE by one cycle
  always_comb begin
    wr_en_d   = PIX_WE && (state_q == StCapture) && (row_q < ROW_LIM) &&
                (PIX_X < LINE_STEP) && !CAP_ABORT;
    wr_addr_d = {wr_bank_q, base_q + PIX_X};
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cont_q      <= 1'b0;
      row_q       <= '0;
      base_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      row_q       <= row_d;
      base_q      <= base_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_en_q     <= wr_en_d;
      if (wr_en_d) wr_addr_q <= wr_addr_d;
    end
  end

  assign WR_EN      = wr_en_q;
  assign WR_ADDR    = wr_addr_q;
  assign RD_BANK    = rd_bank_q;
  assign FRAME_DONE = done_q;
  assign BUSY       = (state_q != StIdle);
  assign FRAME_CNT  = frame_cnt_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Directed bench for frame_capture_sequencer.
`timescale 1ns/1ps
module tb_frame_capture_sequencer;
  import cam_pkg::*;

  logic               CLK = 1'b0;
  logic               RST, VSYNC, HREF, PIX_WE, CAP_START, CAP_ABORT, CAP_CONT, RD_BUSY;
  logic [BANK_AW-1:0] PIX_X;
  logic               WR_EN, RD_BANK, FRAME_DONE, BUSY;
  logic [BANK_AW:0]   WR_ADDR;
  logic [CNT_W-1:0]   FRAME_CNT, DROP_CNT;

  always #5 CLK = ~CLK;

  frame_capture_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .PIX_WE     (PIX_WE),
    .PIX_X      (PIX_X),
    .CAP_START  (CAP_START),
    .CAP_ABORT  (CAP_ABORT),
    .CAP_CONT   (CAP_CONT),
    .RD_BUSY    (RD_BUSY),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .RD_BANK    (RD_BANK),
    .FRAME_DONE (FRAME_DONE),
    .BUSY       (BUSY),
    .FRAME_CNT  (FRAME_CNT),
    .DROP_CNT   (DROP_CNT)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Write/publish monitor; statistics cleared when clr_gen is bumped
  int          clr_gen = 0;
  int          clr_seen = 0;
  int          wr_cnt, done_cnt, seq_err, max_off;
  logic [15:0] first_addr, last_addr;
  bit          got_first;

  always @(negedge CLK) begin
    if (clr_seen != clr_gen) begin
      clr_seen  <= clr_gen;
      wr_cnt    <= 0;
      done_cnt  <= 0;
      seq_err   <= 0;
      max_off   <= 0;
      got_first <= 1'b0;
    end else begin
      if (FRAME_DONE) done_cnt <= done_cnt + 1;
      if (WR_EN) begin
        if (!got_first) begin
          first_addr <= WR_ADDR;
          got_first  <= 1'b1;
        end else if (WR_ADDR != last_addr + 16'd1) begin
          seq_err <= seq_err + 1;
        end
        last_addr <= WR_ADDR;
        if (int'(WR_ADDR[14:0]) > max_off) max_off <= int'(WR_ADDR[14:0]);
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    clr_gen++;
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1; VSYNC = 1'b0; HREF = 1'b0; PIX_WE = 1'b0; PIX_X = '0;
    CAP_START = 1'b0; CAP_ABORT = 1'b0; CAP_CONT = 1'b0; RD_BUSY = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic start(input logic cont);
    CAP_CONT = cont; CAP_START = 1'b1;
    tick();
    CAP_START = 1'b0; CAP_CONT = 1'b0;
  endtask

  // Rising VSYNC edge followed by two quiet cycles
  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int npix);
    HREF = 1'b1;
    for (int x = 0; x < npix; x++) begin
      PIX_WE = 1'b1; PIX_X = 15'(x);
      tick();
    end
    PIX_WE = 1'b0; HREF = 1'b0;
    tick();
  endtask

  task automatic send_lines(input int npix, input int nlines);
    for (int l = 0; l < nlines; l++) send_line(npix);
  endtask

  initial begin
    // 1: single-shot full frame
    do_reset();
    check_eq("rst_busy",   32'(BUSY), 32'd0);
    check_eq("rst_rdbank", 32'(RD_BANK), 32'd1);
    check_eq("rst_wren",   32'(WR_EN), 32'd0);
    check_eq("rst_addr",   32'(WR_ADDR), 32'd0);
    check_eq("rst_done",   32'(FRAME_DONE), 32'd0);
    check_eq("rst_fcnt",   32'(FRAME_CNT), 32'd0);
    check_eq("rst_dcnt",   32'(DROP_CNT), 32'd0);
    start(1'b0);
    check_eq("t1_busy", 32'(BUSY), 32'd1);
    clear_mon();
    vsync_pulse();
    send_lines(176, 144);
    vsync_pulse();
    check_eq("t1_wrcnt",  32'(wr_cnt), 32'd25344);
    check_eq("t1_seqerr", 32'(seq_err), 32'd0);
    check_eq("t1_first",  32'(first_addr), 32'd0);
    check_eq("t1_last",   32'(last_addr), 32'd25343);
    check_eq("t1_done",   32'(done_cnt), 32'd1);
    check_eq("t1_rdbank", 32'(RD_BANK), 32'd0);
    check_eq("t1_fcnt",   32'(FRAME_CNT), 32'd1);
    check_eq("t1_idle",   32'(BUSY), 32'd0);

    // 2: continuous, three short frames
    do_reset();
    start(1'b1);
    clear_mon();
    vsync_pulse();
    send_lines(8, 3);
    check_eq("t2_f1_first", 32'(first_addr), 32'h0000);
    vsync_pulse();
    check_eq("t2_rdbank1", 32'(RD_BANK), 32'd0);
    check_eq("t2_done1",   32'(done_cnt), 32'd1);
    clear_mon();
    send_lines(8, 3);
    check_eq("t2_f2_first", 32'(first_addr), 32'h8000);
    check_eq("t2_f2_last",  32'(last_addr), 32'h8000 + 32'd359);
    vsync_pulse();
    check_eq("t2_rdbank2", 32'(RD_BANK), 32'd1);
    send_lines(8, 3);
    vsync_pulse();
    check_eq("t2_rdbank3", 32'(RD_BANK), 32'd0);
    check_eq("t2_fcnt",    32'(FRAME_CNT), 32'd3);
    check_eq("t2_done",    32'(done_cnt), 32'd2);
    check_eq("t2_busy",    32'(BUSY), 32'd1);

    // 3: continuous with the reader busy over the 2nd frame end
    do_reset();
    start(1'b1);
    vsync_pulse();
    send_lines(8, 2);
    vsync_pulse();
    send_lines(8, 2);
    RD_BUSY = 1'b1;
    vsync_pulse();
    RD_BUSY = 1'b0;
    check_eq("t3_dcnt",   32'(DROP_CNT), 32'd1);
    check_eq("t3_rdbank", 32'(RD_BANK), 32'd0);
    check_eq("t3_fcnt1",  32'(FRAME_CNT), 32'd1);
    clear_mon();
    send_lines(8, 2);
    check_eq("t3_f3_first", 32'(first_addr), 32'h8000);
    vsync_pulse();
    check_eq("t3_fcnt2",   32'(FRAME_CNT), 32'd2);
    check_eq("t3_rdbank2", 32'(RD_BANK), 32'd1);

    // 4: single-shot, reader busy at frame end holds SWAP
    do_reset();
    start(1'b0);
    vsync_pulse();
    send_lines(8, 2);
    clear_mon();
    RD_BUSY = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 48; i++) tick();
    check_eq("t4_busy_hold", 32'(BUSY), 32'd1);
    check_eq("t4_nodone",    32'(done_cnt), 32'd0);
    check_eq("t4_rdbank0",   32'(RD_BANK), 32'd1);
    RD_BUSY = 1'b0;
    tick();
    check_eq("t4_done_hi", 32'(FRAME_DONE), 32'd1);
    check_eq("t4_rdbank",  32'(RD_BANK), 32'd0);
    tick();
    check_eq("t4_done_lo", 32'(FRAME_DONE), 32'd0);
    check_eq("t4_idle",    32'(BUSY), 32'd0);
    check_eq("t4_donecnt", 32'(done_cnt), 32'd1);

    // 5: oversize frame from the camera
    do_reset();
    start(1'b0);
    clear_mon();
    vsync_pulse();
    send_lines(180, 150);
    vsync_pulse();
    check_eq("t5_wrcnt",  32'(wr_cnt), 32'd25344);
    check_eq("t5_maxoff", 32'(max_off), 32'd25343);
    check_eq("t5_fcnt",   32'(FRAME_CNT), 32'd1);

    // 6a: abort during line 70 of the 2nd continuous frame
    do_reset();
    start(1'b1);
    vsync_pulse();
    send_lines(8, 2);
    vsync_pulse();
    check_eq("t6a_rdbank0", 32'(RD_BANK), 32'd0);
    clear_mon();
    send_lines(4, 70);
    HREF = 1'b1;
    for (int x = 0; x < 4; x++) begin
      PIX_WE = 1'b1; PIX_X = 15'(x);
      tick();
    end
    check_eq("t6a_wren_pre", 32'(WR_EN), 32'd1);
    check_eq("t6a_addr",     32'(WR_ADDR), 32'hB023);
    PIX_X = 15'd4; CAP_ABORT = 1'b1;
    tick();
    CAP_ABORT = 1'b0;
    check_eq("t6a_wren", 32'(WR_EN), 32'd0);
    check_eq("t6a_idle", 32'(BUSY), 32'd0);
    PIX_X = 15'd5;
    tick();
    check_eq("t6a_wren2", 32'(WR_EN), 32'd0);
    PIX_WE = 1'b0; HREF = 1'b0;
    tick();
    vsync_pulse();
    check_eq("t6a_nodone", 32'(done_cnt), 32'd0);
    check_eq("t6a_rdbank", 32'(RD_BANK), 32'd0);
    check_eq("t6a_fcnt",   32'(FRAME_CNT), 32'd1);

    // 6b: reset mid-line
    do_reset();
    start(1'b1);
    vsync_pulse();
    send_lines(8, 2);
    vsync_pulse();
    check_eq("t6b_rdbank0", 32'(RD_BANK), 32'd0);
    HREF = 1'b1;
    for (int x = 0; x < 3; x++) begin
      PIX_WE = 1'b1; PIX_X = 15'(x);
      tick();
    end
    RST = 1'b1;
    tick();
    check_eq("t6b_idle",   32'(BUSY), 32'd0);
    check_eq("t6b_wren",   32'(WR_EN), 32'd0);
    check_eq("t6b_addr",   32'(WR_ADDR), 32'd0);
    check_eq("t6b_rdbank", 32'(RD_BANK), 32'd1);
    check_eq("t6b_fcnt",   32'(FRAME_CNT), 32'd0);
    check_eq("t6b_done",   32'(FRAME_DONE), 32'd0);
    RST = 1'b0; PIX_WE = 1'b0; HREF = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
